// File: rtl/gpio_bank_if.sv
// Single-cycle register handshake between the peripheral bus master and gpio_bank.
// The master drives select/write/address/data; the bank returns ack and read data.
interface gpio_bank_if #(
    parameter int WIDTH = 8
);
    logic             reg_sel;
    logic             reg_wr;
    logic [2:0]       reg_addr;
    logic [WIDTH-1:0] reg_wdata;
    logic [WIDTH-1:0] reg_rdata;
    logic             reg_ack;

    modport master (
        output reg_sel, reg_wr, reg_addr, reg_wdata,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_sel, reg_wr, reg_addr, reg_wdata,
        output reg_rdata, reg_ack
    );
endinterface

// File: rtl/gpio_bank.sv
// WIDTH-pin bidirectional GPIO bank: registered pad drive/enable, synchronised inputs,
// per-pin edge interrupts. Define GPIO_DEBOUNCE_EN to insert a per-pin debounce counter.
module gpio_bank #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             core_clk,
    input  logic             core_rstn,
    gpio_bank_if.slave       bus,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oeb,
    input  logic [WIDTH-1:0] pad_in,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("gpio_bank: parameter out of range");
    end

    typedef enum logic {IDLE, ACK} state_t;

    state_t           state_q;
    logic             ack_q;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] dout_q, oeb_q, ien_q, ipol_q, istat_q, istat_d;
    logic [WIDTH-1:0] din_reg_q, din_prev_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] evt, w1c;
    logic             irq_q;
    logic             wr_en;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= pad_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q [WIDTH];

    // A pin has only one candidate value (~DIN), so any bounce back to DIN restarts the count.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            din_reg_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_out[i] == din_reg_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
                    din_reg_q[i] <= sync_out[i];
                    cnt_q[i]     <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) din_reg_q <= '0;
        else            din_reg_q <= sync_out;
    end
`endif

    assign wr_en = (state_q == IDLE) && bus.reg_sel && bus.reg_wr;

    // Events use the IPOL value before any write landing on the same edge.
    assign evt     = (din_reg_q & ~din_prev_q & ipol_q) | (~din_reg_q & din_prev_q & ~ipol_q);
    assign w1c     = (wr_en && bus.reg_addr == 3'd5) ? bus.reg_wdata : '0;
    assign istat_d = (istat_q & ~w1c) | evt;

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            dout_q     <= '0;
            oeb_q      <= '1;
            ien_q      <= '0;
            ipol_q     <= '0;
            istat_q    <= '0;
            din_prev_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            din_prev_q <= din_reg_q;
            istat_q    <= istat_d;
            irq_q      <= |(istat_q & ien_q);
            if (wr_en) begin
                case (bus.reg_addr)
                    3'd0:    dout_q <= bus.reg_wdata;
                    3'd1:    oeb_q  <= bus.reg_wdata;
                    3'd3:    ien_q  <= bus.reg_wdata;
                    3'd4:    ipol_q <= bus.reg_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        case (bus.reg_addr)
            3'd0:    rdata_d = dout_q;
            3'd1:    rdata_d = oeb_q;
            3'd2:    rdata_d = din_reg_q;
            3'd3:    rdata_d = ien_q;
            3'd4:    rdata_d = ipol_q;
            3'd5:    rdata_d = istat_q;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.reg_sel) begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
                        rdata_q <= rdata_d;
                    end else begin
                        ack_q   <= 1'b0;
                        rdata_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    assign bus.reg_ack   = ack_q;
    assign bus.reg_rdata = rdata_q;
    assign pad_out       = dout_q;
    assign pad_oeb       = oeb_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed and randomized bench for gpio_bank with a history-based reference model.
module tb_gpio_bank;
    localparam int W = 8;
    localparam int S = 2;
    localparam int D = 16;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DB = D;
`else
    localparam int DB = 0;
`endif

    logic         core_clk = 1'b0;
    logic         core_rstn = 1'b0;
    logic [W-1:0] pad_out, pad_oeb, pad_in;
    logic         irq;
    int           checks = 0;
    int           errors = 0;

    gpio_bank_if #(.WIDTH(W)) bus ();

    gpio_bank #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
        .core_clk  (core_clk),
        .core_rstn (core_rstn),
        .bus       (bus),
        .pad_out   (pad_out),
        .pad_oeb   (pad_oeb),
        .pad_in    (pad_in),
        .irq       (irq)
    );

    always #5 core_clk = ~core_clk;

    // Reference model: registers as plain variables, inputs as sample histories.
    logic [W-1:0] m_dout, m_oeb, m_ien, m_ipol, m_istat, m_din, m_dinq, m_rdata;
    logic         m_irq, m_ack, m_busy;
    logic [W-1:0] padh[$];
    logic [W-1:0] synh[$];
    logic [W-1:0] mv_evt, mv_clr, mv_rd, mv_sv, mv_nd;
    logic         mv_same;

    function automatic void model_reset();
        m_dout = '0; m_oeb = '1; m_ien = '0; m_ipol = '0; m_istat = '0;
        m_din = '0; m_dinq = '0; m_rdata = '0; m_irq = 1'b0; m_ack = 1'b0; m_busy = 1'b0;
        padh.delete();
        synh.delete();
        repeat (S) padh.push_back('0);
        repeat (D + 1) synh.push_back('0);
    endfunction

    always @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            model_reset();
        end else begin
            mv_evt = (m_din & ~m_dinq & m_ipol) | (~m_din & m_dinq & ~m_ipol);
            m_irq  = |(m_istat & m_ien);
            mv_clr = '0;
            if (!m_busy && bus.reg_sel) begin
                case (bus.reg_addr)
                    3'd0: mv_rd = m_dout;
                    3'd1: mv_rd = m_oeb;
                    3'd2: mv_rd = m_din;
                    3'd3: mv_rd = m_ien;
                    3'd4: mv_rd = m_ipol;
                    3'd5: mv_rd = m_istat;
                    default: mv_rd = '0;
                endcase
                m_rdata = mv_rd; m_ack = 1'b1; m_busy = 1'b1;
                if (bus.reg_wr) begin
                    case (bus.reg_addr)
                        3'd0: m_dout = bus.reg_wdata;
                        3'd1: m_oeb  = bus.reg_wdata;
                        3'd3: m_ien  = bus.reg_wdata;
                        3'd4: m_ipol = bus.reg_wdata;
                        3'd5: mv_clr = bus.reg_wdata;
                        default: ;
                    endcase
                end
            end else begin
                m_rdata = '0; m_ack = 1'b0; m_busy = 1'b0;
            end
            m_istat = (m_istat & ~mv_clr) | mv_evt;
            // Synchronised value seen at this edge is the pad sampled S edges ago.
            mv_sv = padh[S-1];
            padh.push_front(pad_in);
            void'(padh.pop_back());
            m_dinq = m_din;
`ifdef GPIO_DEBOUNCE_EN
            synh.push_front(mv_sv);
            void'(synh.pop_back());
            mv_nd = m_din;
            for (int i = 0; i < W; i++) begin
                mv_same = 1'b1;
                for (int k = 0; k <= D; k++) if (synh[k][i] != synh[0][i]) mv_same = 1'b0;
                if (mv_same && synh[0][i] != m_din[i]) mv_nd[i] = synh[0][i];
            end
`else
            mv_nd = mv_sv;
`endif
            m_din = mv_nd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge core_clk);
        chk("ack", 32'(bus.reg_ack), 32'(m_ack));
        chk("rdata", 32'(bus.reg_rdata), 32'(m_rdata));
        chk("pad_out", 32'(pad_out), 32'(m_dout));
        chk("pad_oeb", 32'(pad_oeb), 32'(m_oeb));
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        bus.reg_sel = 1'b1; bus.reg_wr = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
        tick();
        chk("wr_ack", 32'(bus.reg_ack), 32'd1);
        bus.reg_sel = 1'b0; bus.reg_wr = 1'b0;
        tick();
    endtask

    task automatic rd(input logic [2:0] a, input logic [W-1:0] exp, input string tag);
        bus.reg_sel = 1'b1; bus.reg_wr = 1'b0; bus.reg_addr = a;
        tick();
        chk({tag, "_ack"}, 32'(bus.reg_ack), 32'd1);
        chk(tag, 32'(bus.reg_rdata), 32'(exp));
        bus.reg_sel = 1'b0;
        tick();
        chk({tag, "_ackdrop"}, 32'(bus.reg_ack), 32'd0);
    endtask

    initial begin
        int n;
        bus.reg_sel = 1'b0; bus.reg_wr = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
        pad_in = '0;
        repeat (3) tick();
        chk("rst_pad_oeb", 32'(pad_oeb), 32'hFF);
        chk("rst_pad_out", 32'(pad_out), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_ack", 32'(bus.reg_ack), 32'h0);
        core_rstn = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) rd(3'(a), (a == 1) ? 8'hFF : 8'h00, "rst_read");

        wr(3'd1, 8'hF0);
        wr(3'd0, 8'hA5);
        chk("oeb_pad", 32'(pad_oeb), 32'hF0);
        chk("dout_pad", 32'(pad_out), 32'hA5);
        rd(3'd1, 8'hF0, "oeb_rb");
        rd(3'd0, 8'hA5, "dout_rb");

        wr(3'd3, 8'h01);
        wr(3'd4, 8'h01);
        pad_in[0] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!irq && n < 80);
        chk("irq_latency", 32'(n), 32'(S + 3 + DB));
        rd(3'd5, 8'h01, "istat_rise");
        bus.reg_sel = 1'b1; bus.reg_wr = 1'b1; bus.reg_addr = 3'd5; bus.reg_wdata = 8'h01;
        tick();
        chk("irq_hold", 32'(irq), 32'd1);
        bus.reg_sel = 1'b0; bus.reg_wr = 1'b0;
        tick();
        chk("irq_clear", 32'(irq), 32'd0);

        pad_in[3] = 1'b1;
        repeat (40) tick();
        rd(3'd5, 8'h00, "istat_pre_collide");
        pad_in[3] = 1'b0;
        repeat (S + 1 + DB) tick();
        bus.reg_sel = 1'b1; bus.reg_wr = 1'b1; bus.reg_addr = 3'd5; bus.reg_wdata = 8'h08;
        tick();
        bus.reg_sel = 1'b0; bus.reg_wr = 1'b0;
        tick();
        rd(3'd5, 8'h08, "collide");

        wr(3'd5, 8'h08);
        wr(3'd4, 8'h05);
        pad_in[2] = 1'b1;
        repeat (40) tick();
        chk("masked_irq", 32'(irq), 32'd0);
        rd(3'd5, 8'h04, "masked_istat");
        wr(3'd7, 8'hFF);
        rd(3'd0, 8'hA5, "unm_dout");
        rd(3'd1, 8'hF0, "unm_oeb");
        rd(3'd3, 8'h01, "unm_ien");
        rd(3'd4, 8'h05, "unm_ipol");
        rd(3'd6, 8'h00, "unm_rd6");
        rd(3'd7, 8'h00, "unm_rd7");

`ifdef GPIO_DEBOUNCE_EN
        wr(3'd5, 8'h04);
        wr(3'd4, 8'h07);
        pad_in[1] = 1'b1;
        repeat (10) tick();
        pad_in[1] = 1'b0;
        repeat (40) tick();
        rd(3'd2, 8'h05, "db_glitch_din");
        rd(3'd5, 8'h00, "db_glitch_istat");
        pad_in[1] = 1'b1;
        repeat (S + DB) tick();
        rd(3'd2, 8'h05, "db_early");
        rd(3'd2, 8'h07, "db_update");
        pad_in[1] = 1'b0;
        repeat (40) tick();
`endif

        for (int c = 0; c < 400; c++) begin
`ifdef GPIO_DEBOUNCE_EN
            if ($urandom_range(0, 24) == 0) pad_in = pad_in ^ (W'(1) << $urandom_range(0, W - 1));
`else
            if ($urandom_range(0, 2) == 0) pad_in = pad_in ^ (W'(1) << $urandom_range(0, W - 1));
`endif
            bus.reg_sel   = 1'($urandom_range(0, 1));
            bus.reg_wr    = 1'($urandom_range(0, 1));
            bus.reg_addr  = 3'($urandom_range(0, 7));
            bus.reg_wdata = W'($urandom);
            tick();
        end

        bus.reg_sel = 1'b1; bus.reg_wr = 1'b1; bus.reg_addr = 3'd0; bus.reg_wdata = 8'h3C;
        @(negedge core_clk);
        wait (bus.reg_ack == 1'b0);
        bus.reg_sel = 1'b1;
        @(posedge core_clk);
        #2;
        chk("midacc_ack_before", 32'(bus.reg_ack), 32'd1);
        core_rstn = 1'b0;
        #1;
        chk("midacc_ack", 32'(bus.reg_ack), 32'd0);
        chk("midacc_rdata", 32'(bus.reg_rdata), 32'd0);
        chk("midacc_pad_out", 32'(pad_out), 32'd0);
        chk("midacc_pad_oeb", 32'(pad_oeb), 32'hFF);
        chk("midacc_irq", 32'(irq), 32'd0);
        bus.reg_sel = 1'b0; bus.reg_wr = 1'b0;
        pad_in = '0;
        repeat (2) tick();
        core_rstn = 1'b1;
        tick();
        rd(3'd0, 8'h00, "post_rst_dout");
        rd(3'd1, 8'hFF, "post_rst_oeb");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
